// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, one-outstanding imem req/ack, DEPTH-entry prefetch FIFO to the control unit.
// Ack in cycle N is visible on inst in N+1; requests pause while the FIFO is full, redirect flushes it.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ack,
    input  logic [7:0]        i_imem_rdata,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic [7:0]        o_inst,
    output logic [ADDR_W-1:0] o_inst_pc,
    output logic              o_inst_valid,
    input  logic              i_inst_ready
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DROP} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_req, w_req_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [7:0]        r_buf_inst [DEPTH];
    logic [ADDR_W-1:0] r_buf_pc   [DEPTH];
    logic              w_push, w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_push      = (r_state == S_FETCH) && r_req && i_imem_ack && !i_redirect;
        w_pop       = (r_count != '0) && i_inst_ready && !i_redirect;
        w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_pc_nxt    = r_pc;
        if (i_redirect) begin
            w_count_nxt = '0;
            w_pc_nxt    = i_redirect_pc;
            // An unacked request must stay on the bus; its data is dropped later.
            if (r_req && !i_imem_ack) begin
                w_state_nxt = S_DROP;
            end else begin
                w_state_nxt = S_FETCH;
                w_req_nxt   = 1'b1;
                w_addr_nxt  = i_redirect_pc;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_req) begin
                        if (i_imem_ack) begin
                            w_pc_nxt = r_addr + 1'b1;
                            if (w_count_nxt < FULL) begin
                                w_addr_nxt = r_addr + 1'b1;
                            end else begin
                                w_state_nxt = S_HOLD;
                                w_req_nxt   = 1'b0;
                            end
                        end
                    end else if (r_count < FULL) begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = r_pc;
                    end
                end
                S_HOLD: begin
                    if (w_count_nxt < FULL) begin
                        w_state_nxt = S_FETCH;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                    end
                end
                S_DROP: begin
                    if (i_imem_ack) begin
                        w_state_nxt = S_FETCH;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = r_pc;
                    end
                end
                default: begin
                    w_state_nxt = S_FETCH;
                    w_req_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= S_FETCH;
            r_req    <= 1'b0;
            r_addr   <= RESET_PC;
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
            r_pc    <= w_pc_nxt;
            r_count <= w_count_nxt;
            if (i_redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= i_imem_rdata;
            r_buf_pc[r_wr_ptr]   <= r_addr;
        end
    end

    assign o_imem_req   = r_req;
    assign o_imem_addr  = r_addr;
    assign o_inst_valid = (r_count != '0);
    assign o_inst       = o_inst_valid ? r_buf_inst[r_rd_ptr] : '0;
    assign o_inst_pc    = o_inst_valid ? r_buf_pc[r_rd_ptr] : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed bench for instr_fetch_unit: program-order scoreboard plus bus-protocol checker.
module tb_instr_fetch_unit;
    logic       clk, reset;
    logic       imem_req, imem_ack, redirect, inst_valid, inst_ready;
    logic [7:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;

    int total = 0;
    int bad = 0;
    int n_pop = 0;
    logic [7:0] tbl [256];
    logic [7:0] exp_q [$];

    int   lat_max = 0;
    bit   slow_en = 0;
    bit   stray_ack = 0;
    logic [7:0] slow_addr = 8'h05;

    instr_fetch_unit #(.ADDR_W(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
        .i_clk(clk), .i_reset(reset),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_ack(imem_ack), .i_imem_rdata(imem_rdata),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_inst(inst), .o_inst_pc(inst_pc), .o_inst_valid(inst_valid),
        .i_inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Program order after a reset/redirect is simply target, target+1, ... modulo 256.
    task automatic sb_restart(input logic [7:0] pc);
        exp_q.delete();
        for (int i = 0; i < 4096; i++) exp_q.push_back(pc + 8'(i));
    endtask

    // Memory: one request at a time, latency picked when a request first appears.
    initial begin
        int  lat;
        bit  busy;
        busy = 0;
        lat = 0;
        imem_ack = 1'b0;
        imem_rdata = 8'h00;
        forever begin
            cyc();
            if (!imem_req) begin
                busy = 0;
                imem_ack = stray_ack;
                imem_rdata = stray_ack ? 8'hEE : 8'h00;
            end else begin
                if (!busy) begin
                    busy = 1;
                    lat = (slow_en && imem_addr == slow_addr) ? 3 : $urandom_range(0, lat_max);
                end
                if (lat == 0) begin
                    imem_ack = 1'b1;
                    imem_rdata = tbl[imem_addr];
                    busy = 0;
                end else begin
                    imem_ack = 1'b0;
                    imem_rdata = 8'($urandom);
                    lat--;
                end
            end
        end
    end

    // Scoreboard monitor: every accepted instruction must be the next one in program order.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && !redirect && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", inst_pc, e);
                chk("sb_inst", inst, tbl[e]);
                n_pop++;
            end
        end
        if (!inst_valid) begin
            chk("empty_inst", inst, 0);
            chk("empty_pc", inst_pc, 0);
        end
    end

    // Bus protocol: an unacked request keeps req and addr stable unless reset intervenes.
    always @(negedge clk) begin
        static logic       p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b1;
        static logic [7:0] p_addr = 8'h00;
        if (p_req && !p_ack && !p_rst) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, p_addr);
        end
        p_req = imem_req;
        p_ack = imem_ack;
        p_rst = reset;
        p_addr = imem_addr;
    end

    task automatic do_reset(input int n);
        cyc();
        reset = 1'b1;
        redirect = 1'b0;
        repeat (n) cyc();
        smp();
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_pc", inst_pc, 0);
        sb_restart(8'h00);
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [7:0] pcs [3];
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 8'h00;
        inst_ready = 1'b1;
        for (int i = 0; i < 256; i++) tbl[i] = 8'(i + 16);

        // Start-up and zero-wait streaming.
        do_reset(2);
        smp();
        chk("start_req_low", imem_req, 0);
        cyc(); smp();
        chk("start_req", imem_req, 1);
        chk("start_addr", imem_addr, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(); smp();
            chk("stream_valid", inst_valid, 1);
            chk("stream_pc", inst_pc, k);
            chk("stream_inst", inst, 8'h10 + k);
        end
        // Steady push+pop at one entry: request never drops.
        repeat (10) begin
            cyc(); smp();
            chk("pp_req", imem_req, 1);
            chk("pp_valid", inst_valid, 1);
        end

        // Backpressure fills the buffer and stops requests.
        inst_ready = 1'b0;
        do_reset(2);
        repeat (2) cyc();
        repeat (4) begin
            cyc(); smp();
            chk("bp_req", imem_req, 0);
            chk("bp_inst", inst, 8'h10);
        end
        cyc(); inst_ready = 1'b1;
        cyc(); inst_ready = 1'b0;
        smp();
        chk("bp_rereq", imem_req, 1);
        chk("bp_readdr", imem_addr, 2);
        chk("bp_head", inst, 8'h11);
        inst_ready = 1'b1;

        // Redirect while address 0x05 is outstanding.
        slow_en = 1;
        do_reset(2);
        n = 0;
        smp();
        while (!(imem_req && imem_addr == 8'h05) && n < 20) begin
            cyc(); smp(); n++;
        end
        chk("wait_addr5", imem_addr, 8'h05);
        cyc();
        redirect = 1'b1;
        redirect_pc = 8'h40;
        sb_restart(8'h40);
        cyc();
        redirect = 1'b0;
        smp();
        chk("rd_valid_off", inst_valid, 0);
        n = 0;
        while (!imem_ack && n < 10) begin
            chk("drop_req", imem_req, 1);
            chk("drop_addr", imem_addr, 8'h05);
            cyc(); smp(); n++;
        end
        chk("drop_timeout", int'(n < 10), 1);
        chk("drop_ack_addr", imem_addr, 8'h05);
        cyc(); smp();
        chk("rd_new_req", imem_req, 1);
        chk("rd_new_addr", imem_addr, 8'h40);
        n = 0;
        while (!inst_valid && n < 10) begin
            cyc(); smp(); n++;
        end
        chk("rd_first_pc", inst_pc, 8'h40);
        slow_en = 0;

        // PC wrap.
        cyc();
        redirect = 1'b1;
        redirect_pc = 8'hFE;
        sb_restart(8'hFE);
        cyc();
        redirect = 1'b0;
        smp();
        chk("wrap_valid_off", inst_valid, 0);
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (inst_valid) begin
                pcs[n] = inst_pc;
                n++;
            end
            cyc(); smp();
        end
        chk("wrap_cnt", n, 3);
        chk("wrap_pc0", pcs[0], 8'hFE);
        chk("wrap_pc1", pcs[1], 8'hFF);
        chk("wrap_pc2", pcs[2], 8'h00);

        // Reset with a request on the bus and the buffer occupied; stray ack afterwards.
        inst_ready = 1'b0;
        do_reset(2);
        cyc(); cyc(); smp();
        chk("mid_pre_req", imem_req, 1);
        chk("mid_pre_valid", inst_valid, 1);
        reset = 1'b1;
        stray_ack = 1;
        sb_restart(8'h00);
        cyc(); smp();
        chk("mid_valid", inst_valid, 0);
        chk("mid_req", imem_req, 0);
        cyc();
        reset = 1'b0;
        smp();
        chk("stray_valid", inst_valid, 0);
        chk("stray_req", imem_req, 0);
        stray_ack = 0;
        cyc(); smp();
        chk("restart_req", imem_req, 1);
        chk("restart_addr", imem_addr, 0);
        chk("restart_valid", inst_valid, 0);
        inst_ready = 1'b1;

        // Random traffic: memory latency, consumer stalls, redirects.
        lat_max = 3;
        for (int i = 0; i < 256; i++) tbl[i] = 8'($urandom);
        do_reset(2);
        for (int c = 0; c < 3000; c++) begin
            cyc();
            inst_ready = ($urandom_range(0, 9) < 7);
            redirect = ($urandom_range(0, 99) < 3);
            if (redirect) begin
                redirect_pc = 8'($urandom);
                sb_restart(redirect_pc);
            end
        end
        cyc();
        redirect = 1'b0;
        smp();
        chk("progress", int'(n_pop > 500), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetches 8-bit instructions from instruction memory over a req/ack handshake and presents them, in program order, to the control unit's `inst` input through a small prefetch buffer with a valid/ready handshake. Maintains the program counter, supports redirection (jumps or branches) with buffer flush and cancellation of the in-flight fetch, and throttles itself when the consumer stalls. It sits between instruction memory and the control unit.

## Interface
- `ADDR_W`, 8, program-counter and instruction-memory address width.
- `DEPTH`, 2, prefetch buffer entries; must be ≥1.
- `RESET_PC`, 0, PC value loaded on reset.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  ADDR_W  fetch address; stable while `imem_req` is high.
- `imem_ack`  in  1  one-cycle acknowledge; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  8  fetched instruction byte.
- `redirect`  in  1  one-cycle pulse that loads a new PC and flushes the buffer.
- `redirect_pc`  in  ADDR_W  new PC, sampled when `redirect` is high.
- `inst`  out  8  head-of-buffer instruction, sent to the control unit.
- `inst_pc`  out  ADDR_W  address of `inst`.
- `inst_valid`  out  1  the buffer is non-empty.
- `inst_ready`  in  1  the consumer accepts the head entry.

## Operation
- State machine states:
  - FETCH: `imem_req` is high.
  - HOLD: `imem_req` is low because the buffer is full.
  - DROP: `imem_req` is high for a cancelled fetch.
- The buffer is a circular FIFO of {instruction, PC} entries, with `count` in 0..DEPTH.
  - Pop occurs when `inst_valid & inst_ready`.
  - Push occurs on `imem_ack` in FETCH.
  - Push and pop can occur in the same cycle; `count` is unchanged in that case.
- In FETCH, on `imem_ack`:
  - The {`imem_rdata`, `imem_addr`} pair is pushed and the PC increments modulo 2^ADDR_W (0xFF→0x00).
  - Next state is FETCH with the new `imem_addr` if `count_next < DEPTH`, otherwise HOLD.
- In HOLD, the unit returns to FETCH the cycle after `count_next < DEPTH`.
- A request is issued only when `count < DEPTH`, with at most one request outstanding, so a push never overflows.
- Once asserted, `imem_req` and `imem_addr` must not change until ack. This applies across a redirect as well.
- Redirect has priority over everything else:
  - The buffer is cleared (`count`=0, pointers reset), and any pop in the same cycle is discarded.
  - The PC is set to `redirect_pc`.
  - If a request is outstanding and not acked in the redirect cycle, the state becomes DROP. In DROP, `imem_req` and the old address are held until ack, the returned data is discarded, and the unit then goes to FETCH at the new PC.
  - If the outstanding request is acked in the redirect cycle, its data is discarded and the next state is FETCH at `redirect_pc`.
  - From HOLD, the next state is FETCH at `redirect_pc`.
- A redirect while in DROP updates the target PC; the unit stays in DROP.
- `imem_ack` while `imem_req` is low is ignored.
- `inst` and `inst_pc` reflect the head entry and are driven to 0 when the buffer is empty.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC.
  - `inst`=0, `inst_pc`=0, `inst_valid`=0.
  - State FETCH-pending with `count`=0.
- Start-up: the first cycle after reset deasserts has `imem_req`=1 with `imem_addr`=RESET_PC.
- Latency: an ack in cycle N (accepted push) gives `inst_valid`=1 with that entry in cycle N+1, if the buffer was empty.
- Throughput: with ack in the same cycle as req, and a consumer always ready, the unit delivers 1 instruction per cycle.
- Redirect in cycle N:
  - `inst_valid`=0 in cycle N+1.
  - If no fetch is outstanding, the request for `redirect_pc` is issued in cycle N+1.
- Reset asserted mid-fetch: `imem_req` drops in the next cycle and the buffer is cleared. A late ack is ignored.
- All outputs are registered or derived only from registered state, with no combinational input→output path.

## Test plan
- **Reset then zero-wait memory, `inst_ready`=1.** Memory returns data=addr+0x10. Required: `inst`=0x10,0x11,0x12 with `inst_pc`=0,1,2 in consecutive cycles, starting 2 cycles after reset release.
- **Backpressure, DEPTH=2, `inst_ready`=0.** Required:
  - After 2 acks, `imem_req`=0 and `inst` stays at the first fetched byte.
  - Raising `inst_ready` for 1 cycle causes `imem_req` to reassert with the next address.
- **Redirect with a fetch outstanding.** Ack delayed 3 cycles on address 0x05; `redirect`=1 with `redirect_pc`=0x40. Required:
  - `imem_addr` is held at 0x05 until ack and that data never appears.
  - The next request is 0x40, and the first valid output has `inst_pc`=0x40.
- **PC wrap.** `redirect_pc`=0xFE. Required: `inst_pc` sequence 0xFE, 0xFF, 0x00.
- **Simultaneous push and pop at `count`=DEPTH−1 with zero-wait memory.** Required: `count` is unchanged, `imem_req` stays high, and no entry is lost or duplicated.
- **Reset asserted while `imem_req`=1 and the buffer is non-empty.** Required:
  - Next cycle: `inst_valid`=0, `imem_req`=0.
  - A stray ack is ignored.
  - After release, fetching restarts at RESET_PC.
